imm_extend_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator: the next generation of the datapath extender.
//  - Takes 24-bit instruction immediate fields from decode over a valid/ready handshake.
//  - Returns XLEN-wide extended immediates two cycles later, with full backpressure.
//  - Adds an ARM-style rotated 8-bit immediate mode and a per-result illegal-mode flag.
//  - Sits between decode and the execute-stage operand mux.

---
 rtl/imm_extend_pipe.sv | 112 +++++++++++
 tb/tb_imm_extend_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender.
//   S1 holds the raw request {instr, immsrc, tag}. S2 holds the extended result
//   and drives the out_* ports. It has full backpressure and delivers one result per cycle.
//   Optional macro IMM_ROT_EN adds the rotated 8-bit immediate as mode 11.
//   Without IMM_ROT_EN, mode 11 is flagged illegal and counted in err_count.
module imm_extend_pipe #(
    parameter int XLEN     = 32,
    parameter int INSTR_W  = 24,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [1:0]         in_immsrc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   err_count
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [1:0]         immsrc;
        logic [TAG_W-1:0]   tag;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } rsp_t;

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (result on the ports)
    logic [2:1] vld_pipe;
    req_t       s1_q;
    rsp_t       s2_q;
    rsp_t       s2_d;
    logic       s1_adv;
    logic       s2_adv;

    assign s2_adv      = !vld_pipe[2] || out_ready;
    assign s1_adv      = !vld_pipe[1] || s2_adv;
    assign in_ready    = s1_adv;
    assign out_valid   = vld_pipe[2];
    assign out_imm     = s2_q.imm;
    assign out_tag     = s2_q.tag;
    assign out_illegal = s2_q.illegal;

`ifdef IMM_ROT_EN
    // Rotated immediate: the 8-bit value is rotated right by twice the 4-bit field.
    // It is duplicated into a double-width word, so a plain right shift acts as a rotate.
    logic [31:0]       rot_amt;
    logic [2*XLEN-1:0] rot_dbl;
    assign rot_amt = {27'd0, s1_q.instr[11:8], 1'b0} % 32'(XLEN);
    assign rot_dbl = {XLEN'(s1_q.instr[7:0]), XLEN'(s1_q.instr[7:0])} >> rot_amt;
`endif

    // Extend the S1 immediate according to its mode
    always_comb begin
        s2_d.tag     = s1_q.tag;
        s2_d.illegal = 1'b0;
        s2_d.imm     = '0;
        case (s1_q.immsrc)
            2'b00: s2_d.imm = XLEN'(s1_q.instr[7:0]);
            2'b01: s2_d.imm = XLEN'(s1_q.instr[11:0]);
            2'b10: s2_d.imm = XLEN'($signed(s1_q.instr)) << BR_SHIFT;
            default: begin
`ifdef IMM_ROT_EN
                s2_d.imm     = rot_dbl[XLEN-1:0];
`else
                s2_d.imm     = '0;
                s2_d.illegal = 1'b1;
`endif
            end
        endcase
    end

    // Stage registers.
    // Each stage loads only when the stage ahead can make room.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2_q <= s2_d;
            end
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= '{instr: in_instr, immsrc: in_immsrc, tag: in_tag};
            end
        end
    end

    // Count illegal results as they are handed off, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!reset_n)
            err_count <= '0;
        else if (vld_pipe[2] && out_ready && s2_q.illegal && !(&err_count))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed stimulus with a queue-based reference model.
// The model is checked on every cycle, and literal expectations pin the model itself.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic [1:0]  in_immsrc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [3:0]  out_tag;
    logic        out_illegal;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    imm_extend_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the mode rules
    function automatic exp_t model(input logic [23:0] instr, input logic [1:0] m, input logic [3:0] tag);
        exp_t   e;
        longint v, x, n;
        e.tag = tag;
        e.ill = 1'b0;
        v = 0;
        case (m)
            2'd0: v = longint'(instr) % 256;
            2'd1: v = longint'(instr) % 4096;
            2'd2: begin
                v = longint'(instr);
                if (v >= 64'h800000) v = v - 64'h1000000;
                v = v * 4;
            end
            default: begin
`ifdef IMM_ROT_EN
                x = longint'(instr) % 256;
                n = (2 * ((longint'(instr) / 256) % 16)) % 32;
                v = (x >> n) | (x << (32 - n));
`else
                x = 0; n = 0;
                v = 0;
                e.ill = 1'b1;
`endif
            end
        endcase
        e.imm = v[31:0];
        return e;
    endfunction

    // Model state and the per-cycle compare process.
    // Inputs change just after posedge, so the negedge view is what the next edge samples.
    exp_t q[$];
    int   exp_err = 0;
    logic held_v = 1'b0;
    logic [31:0] held_imm;
    logic [3:0]  held_tag;
    logic        held_ill;

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            exp_err = 0;
            held_v  = 1'b0;
        end else begin
            chk("mdl_err_count", err_count, exp_err);
            chk("mdl_in_ready", in_ready, !(q.size() >= 2 && !out_ready));
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_imm", out_imm, held_imm);
                chk("hold_tag", out_tag, held_tag);
                chk("hold_ill", out_illegal, held_ill);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("mdl_unexpected_out", out_valid, 0);
                end else begin
                    chk("mdl_imm", out_imm, q[0].imm);
                    chk("mdl_tag", out_tag, q[0].tag);
                    chk("mdl_ill", out_illegal, q[0].ill);
                    if (out_ready) begin
                        if (q[0].ill && exp_err < 255) exp_err++;
                        void'(q.pop_front());
                    end
                end
            end
            held_v   = out_valid && !out_ready;
            held_imm = out_imm;
            held_tag = out_tag;
            held_ill = out_illegal;
            if (in_valid && in_ready) q.push_back(model(in_instr, in_immsrc, in_tag));
        end
    end

    // Present a request from posedge+1 and hold it until accepted; returns at posedge+1
    task automatic send(input logic [23:0] i, input logic [1:0] m, input logic [3:0] t);
        int n = 0;
        in_valid  = 1'b1;
        in_instr  = i;
        in_immsrc = m;
        in_tag    = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single request into an empty pipe with out_ready=1; checks latency and value
    task automatic one(input string name, input logic [23:0] i, input logic [1:0] m,
                       input logic [3:0] t, input logic [31:0] eimm, input logic eill);
        send(i, m, t);
        @(negedge clk);
        chk({name, "_lat1"}, out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_imm"}, out_imm, eimm);
        chk({name, "_tag"}, out_tag, t);
        chk({name, "_ill"}, out_illegal, eill);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_ill", out_illegal, 0);
        chk("rst_err", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // directed modes with literal expectations
        one("m00", 24'h0012AB, 2'b00, 4'h5, 32'h000000AB, 1'b0);
        one("m01", 24'hABCFED, 2'b01, 4'h6, 32'h00000FED, 1'b0);
        one("m10n", 24'hFFFFFE, 2'b10, 4'h7, 32'hFFFFFFF8, 1'b0);
        one("m10p", 24'h000010, 2'b10, 4'h8, 32'h00000040, 1'b0);
        one("m10max", 24'h7FFFFF, 2'b10, 4'h9, 32'h01FFFFFC, 1'b0);
`ifdef IMM_ROT_EN
        one("m11", 24'h000AFF, 2'b11, 4'hA, 32'h000FF000, 1'b0);
        one("m11r0", 24'h000080, 2'b11, 4'hB, 32'h00000080, 1'b0);
        one("m11r2", 24'h000103, 2'b11, 4'hC, 32'hC0000000, 1'b0);
        @(negedge clk);
        chk("m11_err", err_count, 0);
`else
        one("m11", 24'h000AFF, 2'b11, 4'hA, 32'h00000000, 1'b1);
        @(negedge clk);
        chk("m11_err", err_count, 1);
`endif
        @(posedge clk); #1;

        // back-to-back stream of mixed modes (model checks values and order)
        send(24'h000001, 2'b00, 4'h1);
        send(24'h800000, 2'b10, 4'h2);
        send(24'h000FFF, 2'b01, 4'h3);
        send(24'h123456, 2'b00, 4'h4);
        repeat (4) @(posedge clk); #1;

        // backpressure: tags 1,2 accepted, tag 3 stuck, outputs held
        out_ready = 1'b0;
        send(24'h000011, 2'b00, 4'h1);
        send(24'h000022, 2'b00, 4'h2);
        in_valid  = 1'b1;
        in_instr  = 24'h000033;
        in_immsrc = 2'b00;
        in_tag    = 4'h3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_tag", out_tag, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", in_ready, 1);
        chk("drain_tag1", out_tag, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid2", out_valid, 1);
        chk("drain_tag2", out_tag, 2);
        @(negedge clk);
        chk("drain_valid3", out_valid, 1);
        chk("drain_tag3", out_tag, 3);
        chk("drain_imm3", out_imm, 32'h33);
        @(negedge clk);
        chk("drain_empty", out_valid, 0);
        @(posedge clk); #1;

        // reset with two requests in flight
        out_ready = 1'b0;
        send(24'h000AFF, 2'b11, 4'hD);
        send(24'h000AFF, 2'b11, 4'hE);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_err", err_count, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;

        // 300 mode-11 requests: saturates when illegal, stays zero when rotation is built
        for (int k = 0; k < 300; k++) send(24'h000AFF, 2'b11, k[3:0]);
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef IMM_ROT_EN
        chk("sat_err", err_count, 8'h00);
`else
        chk("sat_err", err_count, 8'hFF);
`endif
        chk("sat_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
